// File: rtl/alu_issue_arbiter.sv
// Two-requester round-robin issue stage for the ALU pipeline.
// Holds back RAW-hazarded requests and drives a harmless bubble when idle.
module alu_issue_arbiter #(
    parameter logic [3:0] NOP_FUNC  = 4'd15,
    parameter logic [3:0] SINK_RD   = 4'd0,
    parameter logic [7:0] SINK_ADDR = 8'd255,
    parameter int         HAZ_DEPTH = 1
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_rs1,
    input  logic [3:0]  req0_rs2,
    input  logic [3:0]  req0_rd,
    input  logic [3:0]  req0_func,
    input  logic [7:0]  req0_addr,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_rs1,
    input  logic [3:0]  req1_rs2,
    input  logic [3:0]  req1_rd,
    input  logic [3:0]  req1_func,
    input  logic [7:0]  req1_addr,
    output logic [3:0]  alu_rs1,
    output logic [3:0]  alu_rs2,
    output logic [3:0]  alu_rd,
    output logic [3:0]  alu_func,
    output logic [7:0]  alu_addr,
    output logic        issue_valid,
    output logic        issue_src,
    output logic [15:0] issue_count,
    output logic [15:0] stall_count
);

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } op_t;

    localparam op_t BUBBLE = '{4'd0, 4'd0, SINK_RD, NOP_FUNC, SINK_ADDR};

    op_t                        r_op;
    logic                       r_valid;
    logic                       r_src;
    logic                       r_last;
    logic [15:0]                r_icnt;
    logic [15:0]                r_scnt;
    logic [HAZ_DEPTH-1:0]       r_tag_v;
    logic [HAZ_DEPTH-1:0][3:0]  r_tag_rd;

    op_t  w_op0;
    op_t  w_op1;
    op_t  w_op;
    logic w_blk0;
    logic w_blk1;
    logic w_el0;
    logic w_el1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_any;
    logic w_stall;
    logic w_tag_v;

    assign w_op0 = '{req0_rs1, req0_rs2, req0_rd, req0_func, req0_addr};
    assign w_op1 = '{req1_rs1, req1_rs2, req1_rd, req1_func, req1_addr};

    // Tags never hold SINK_RD, so scratch reads can never match.
    always_comb begin
        w_blk0 = 1'b0;
        w_blk1 = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (r_tag_v[i]) begin
                if (req0_rs1 == r_tag_rd[i] || req0_rs2 == r_tag_rd[i])
                    w_blk0 = 1'b1;
                if (req1_rs1 == r_tag_rd[i] || req1_rs2 == r_tag_rd[i])
                    w_blk1 = 1'b1;
            end
        end
    end

    assign w_el0   = req0_valid && !w_blk0;
    assign w_el1   = req1_valid && !w_blk1;
    assign w_gnt0  = w_el0 && (!w_el1 || r_last);
    assign w_gnt1  = w_el1 && (!w_el0 || !r_last);
    assign w_any   = w_gnt0 || w_gnt1;
    assign w_op    = w_gnt1 ? w_op1 : w_op0;
    assign w_stall = (req0_valid || req1_valid) && !w_any;
    assign w_tag_v = w_any && (w_op.rd != SINK_RD);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= BUBBLE;
            r_valid  <= 1'b0;
            r_src    <= 1'b0;
            r_last   <= 1'b1;
            r_icnt   <= 16'd0;
            r_scnt   <= 16'd0;
            r_tag_v  <= '0;
            r_tag_rd <= '0;
        end else begin
            r_op    <= w_any ? w_op : BUBBLE;
            r_valid <= w_any;
            r_src   <= w_gnt1;
            if (w_any)
                r_last <= w_gnt1;
            if (w_any && r_icnt != 16'hFFFF)
                r_icnt <= r_icnt + 16'd1;
            if (w_stall && r_scnt != 16'hFFFF)
                r_scnt <= r_scnt + 16'd1;
            for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_rd[i] <= r_tag_rd[i-1];
            end
            r_tag_v[0]  <= w_tag_v;
            r_tag_rd[0] <= w_op.rd;
        end
    end

    assign alu_rs1     = r_op.rs1;
    assign alu_rs2     = r_op.rs2;
    assign alu_rd      = r_op.rd;
    assign alu_func    = r_op.func;
    assign alu_addr    = r_op.addr;
    assign issue_valid = r_valid;
    assign issue_src   = r_src;
    assign issue_count = r_icnt;
    assign stall_count = r_scnt;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Randomized + directed bench for alu_issue_arbiter against a
// cycle-indexed behavioural model of issue, hazards and counters.
module tb_alu_issue_arbiter;

    localparam int HAZ = 1;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_rs1, req0_rs2, req0_rd, req0_func;
    logic [3:0]  req1_rs1, req1_rs2, req1_rd, req1_func;
    logic [7:0]  req0_addr, req1_addr;
    logic [3:0]  alu_rs1, alu_rs2, alu_rd, alu_func;
    logic [7:0]  alu_addr;
    logic        issue_valid, issue_src;
    logic [15:0] issue_count, stall_count;

    always #5 clk1 = ~clk1;

    alu_issue_arbiter #(.HAZ_DEPTH(HAZ)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_rd(req0_rd),
        .req0_func(req0_func), .req0_addr(req0_addr),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_rd(req1_rd),
        .req1_func(req1_func), .req1_addr(req1_addr),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd),
        .alu_func(alu_func), .alu_addr(alu_addr),
        .issue_valid(issue_valid), .issue_src(issue_src),
        .issue_count(issue_count), .stall_count(stall_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model state: cycle index and the cycle each register was last targeted.
    int cyc;
    int last_wr[16];
    int m_last;
    int m_icnt, m_scnt;
    bit m_g0, m_g1;
    logic [3:0] e_rs1, e_rs2, e_rd, e_func;
    logic [7:0] e_addr;
    bit e_valid, e_src;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit blocked(input logic [3:0] a, input logic [3:0] b);
        bit ba, bb;
        ba = (a != 4'd0) && (cyc - last_wr[a] <= HAZ);
        bb = (b != 4'd0) && (cyc - last_wr[b] <= HAZ);
        return ba || bb;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int r = 0; r < 16; r++) last_wr[r] = -1000;
        m_last = 1;
        m_icnt = 0;
        m_scnt = 0;
        m_g0 = 0;
        m_g1 = 0;
    endtask

    task automatic chk_outputs();
        chk("alu_rs1", alu_rs1, e_rs1);
        chk("alu_rs2", alu_rs2, e_rs2);
        chk("alu_rd", alu_rd, e_rd);
        chk("alu_func", alu_func, e_func);
        chk("alu_addr", alu_addr, e_addr);
        chk("issue_valid", issue_valid, e_valid);
        chk("issue_src", issue_src, e_src);
        chk("issue_count", issue_count, m_icnt);
        chk("stall_count", stall_count, m_scnt);
    endtask

    task automatic chk_bubble_reset();
        chk("rst_rs1", alu_rs1, 0);
        chk("rst_rs2", alu_rs2, 0);
        chk("rst_rd", alu_rd, 0);
        chk("rst_func", alu_func, 15);
        chk("rst_addr", alu_addr, 255);
        chk("rst_valid", issue_valid, 0);
        chk("rst_src", issue_src, 0);
        chk("rst_icnt", issue_count, 0);
        chk("rst_scnt", stall_count, 0);
    endtask

    task automatic cycle();
        bit el0, el1;
        @(negedge clk1);
        el0 = req0_valid && !blocked(req0_rs1, req0_rs2);
        el1 = req1_valid && !blocked(req1_rs1, req1_rs2);
        m_g0 = el0 && (!el1 || m_last == 1);
        m_g1 = el1 && !m_g0;
        chk("req0_ready", req0_ready, m_g0);
        chk("req1_ready", req1_ready, m_g1);
        if (m_g0) begin
            {e_rs1, e_rs2, e_rd, e_func, e_addr} =
                {req0_rs1, req0_rs2, req0_rd, req0_func, req0_addr};
        end else if (m_g1) begin
            {e_rs1, e_rs2, e_rd, e_func, e_addr} =
                {req1_rs1, req1_rs2, req1_rd, req1_func, req1_addr};
        end else begin
            {e_rs1, e_rs2, e_rd, e_func, e_addr} = {4'd0, 4'd0, 4'd0, 4'd15, 8'd255};
        end
        e_valid = m_g0 || m_g1;
        e_src = m_g1;
        if (e_valid) begin
            if (e_rd != 4'd0) last_wr[e_rd] = cyc;
            m_last = m_g1 ? 1 : 0;
            if (m_icnt < 65535) m_icnt++;
        end else if ((req0_valid || req1_valid) && m_scnt < 65535) begin
            m_scnt++;
        end
        cyc++;
        @(posedge clk1);
        #1;
        chk_outputs();
    endtask

    task automatic set0(input bit v, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic [3:0] f,
                        input logic [7:0] ad);
        req0_valid = v; req0_rs1 = a; req0_rs2 = b;
        req0_rd = d; req0_func = f; req0_addr = ad;
    endtask

    task automatic set1(input bit v, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic [3:0] f,
                        input logic [7:0] ad);
        req1_valid = v; req1_rs1 = a; req1_rs2 = b;
        req1_rd = d; req1_func = f; req1_addr = ad;
    endtask

    // Hold an unaccepted request stable; otherwise present a new one or go idle.
    task automatic rnd_drive();
        if (!req0_valid || m_g0) begin
            set0($urandom_range(0, 3) != 0, 4'($urandom_range(0, 5)),
                 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                 4'($urandom), 8'($urandom));
        end
        if (!req1_valid || m_g1) begin
            set1($urandom_range(0, 3) != 0, 4'($urandom_range(0, 5)),
                 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                 4'($urandom), 8'($urandom));
        end
    endtask

    int tie_exp[4] = '{0, 1, 0, 1};
    int s_before;

    initial begin
        rst_n = 1'b0;
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk1);
        #1;
        chk_bubble_reset();
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        rst_n = 1'b1;

        // Independent stream on req0: r3+r5->r10, r3*r8->r12
        set0(1, 3, 5, 10, 0, 125);
        cycle();
        chk("ind_valid0", issue_valid, 1);
        set0(1, 3, 8, 12, 2, 126);
        cycle();
        chk("ind_valid1", issue_valid, 1);
        chk("ind_rd", alu_rd, 12);
        chk("ind_count", issue_count, 2);

        // RAW on r10: exactly one bubble
        set0(1, 1, 2, 10, 0, 100);
        cycle();
        set0(1, 10, 0, 11, 0, 101);
        cycle();
        chk("raw_bubble_valid", issue_valid, 0);
        chk("raw_bubble_rd", alu_rd, 0);
        chk("raw_bubble_func", alu_func, 15);
        chk("raw_stall", stall_count, 1);
        cycle();
        chk("raw_accept_valid", issue_valid, 1);
        chk("raw_accept_rd", alu_rd, 11);

        // Hazarded req0 must not stall an independent req1
        set0(1, 1, 2, 10, 0, 102);
        cycle();
        s_before = stall_count;
        set0(1, 10, 1, 9, 3, 103);
        set1(1, 3, 4, 7, 4, 104);
        cycle();
        chk("blk_src", issue_src, 1);
        chk("blk_valid", issue_valid, 1);
        chk("blk_stall", stall_count, s_before);
        set1(0, 0, 0, 0, 0, 0);
        cycle();
        chk("blk_req0_src", issue_src, 0);
        chk("blk_req0_rd", alu_rd, 9);
        set0(0, 0, 0, 0, 0, 0);
        cycle();

        for (int i = 0; i < 3000; i++) begin
            rnd_drive();
            cycle();
        end

        // Reset mid-stream with both valid, then a 0,1,0,1 tie pattern
        set0(1, 1, 2, 13, 5, 10);
        set1(1, 3, 4, 14, 6, 20);
        rst_n = 1'b0;
        #1;
        chk_bubble_reset();
        model_reset();
        @(posedge clk1);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("tie_src", issue_src, tie_exp[k]);
            chk("tie_valid", issue_valid, 1);
        end

        for (int i = 0; i < 1000; i++) begin
            rnd_drive();
            cycle();
        end
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Issue controller in front of the 4-stage register/ALU/memory pipeline. Two requesters each submit operations (rs1, rs2, rd, func, addr) over a valid/ready handshake. The block arbitrates round-robin between them and holds back any operation that reads a register an in-flight operation has not yet written back. On idle cycles it drives a harmless bubble so the pipeline never writes a live register.

## Interface
- `NOP_FUNC`, 4'd15: func code driven on bubbles; the ALU decodes it to a zero result.
- `SINK_RD`, 4'd0: destination register for bubbles; reserved as a scratch register.
- `SINK_ADDR`, 8'd255: memory address for bubbles; reserved scratch word.
- `HAZ_DEPTH`, 1: cycles a destination tag stays busy after issue; legal range 1–4.

Ports:
- `clk1` in 1: single clock, all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 presents an operation.
- `req0_ready` out 1: combinational; requester 0's operation is accepted this cycle.
- `req0_rs1`, `req0_rs2`, `req0_rd` in 4 each: register indices.
- `req0_func` in 4: ALU function code.
- `req0_addr` in 8: memory writeback address.
- `req1_*`: same set of signals for requester 1.
- `alu_rs1`, `alu_rs2`, `alu_rd`, `alu_func` out 4 each: registered, drive the pipeline inputs.
- `alu_addr` out 8: registered, drives the pipeline memory address.
- `issue_valid` out 1: registered; the current `alu_*` fields are a real operation.
- `issue_src` out 1: registered; requester index of the current operation, 0 on bubbles.
- `issue_count` out 16: saturating count of accepted operations.
- `stall_count` out 16: saturating count of cycles with at least one valid request and no issue.

## Operation
**Handshake**
- Transfer happens on the posedge where `reqN_valid && reqN_ready`.
- A requester holds all fields stable while valid is high and ready is low.
- Ready never depends on the same requester's ready.

**Hazard check (per requester, combinational)**
- The block keeps a busy-tag shift register of `HAZ_DEPTH` entries, each holding valid plus a 4-bit rd.
- A request is blocked if `rs1` or `rs2` equals any valid tag.
- Tags are loaded only for real issues with `rd != SINK_RD`. Bubbles load an invalid tag.
- Reads of `SINK_RD` are never blocked; the value read is undefined.

**Arbitration**
- A requester is eligible when it is valid and not blocked.
- If one requester is eligible, it is granted.
- If both are eligible, grant goes to the requester not granted last. The `last` pointer updates only on issue.
- At most one grant per cycle. A blocked requester never stalls the other.

**Issue register**
- On a grant, `alu_*` load the granted fields, `issue_valid=1`, and `issue_src` is set to the winner.
- Otherwise a bubble is driven: `alu_rs1=alu_rs2=0`, `alu_rd=SINK_RD`, `alu_func=NOP_FUNC`, `alu_addr=SINK_ADDR`, `issue_valid=0`, `issue_src=0`.
- The granted tag shifts into entry 0; all other entries shift by one.

**Counters**
- `issue_count` increments on each grant and saturates at 16'hFFFF.
- `stall_count` increments when `(req0_valid || req1_valid)` and there is no grant; it saturates at 16'hFFFF.

**Reset (async assert, sync release)**
- All `alu_*` outputs go to bubble values; `issue_valid=0`, `issue_src=0`.
- All tags become invalid, `last=1` (so req0 wins the first tie), and both counters are 0.
- Reset asserted mid-stream drops any in-flight handshake. Requesters must re-present after release.

## Timing
- Accept at posedge t. `alu_*` change just after t and are held for the whole cycle, so `func` stays stable through the pipeline's negedge decode.
- The pipeline samples `alu_*` at t+1 and writes the register bank at t+2.
- With `HAZ_DEPTH=1`, a dependent operation is blocked at t+1 and accepted at t+2 at the earliest. Back-to-back dependent operations therefore carry exactly one bubble.
- Independent operations issue one per cycle with no bubbles.
- Ready is asserted in the same cycle as valid when the request is eligible and wins arbitration: zero-cycle accept.

## Test plan
- **Reset:** hold `rst_n=0` → all `alu_*` = (0,0,0,15,255), `issue_valid=0`, both counters 0, both readies 0 while valids are 0.
- **Independent stream on req0:** add r3+r5→r10, then mul r3*r8→r12, with req1 idle → accepts on consecutive cycles, no bubble. `issue_count=2`, and after drain mem[125..126]=8,24 (with regbank preloaded r[k]=k).
- **RAW:** req0 issues rd=10, then rs1=10 → second request's ready is low for 1 cycle and one bubble is driven (`alu_rd=0`, `alu_func=15`), then it is accepted. `stall_count=1`.
- **Tie:** both valid and independent for 4 cycles → grants go 0,1,0,1 and `issue_src` toggles.
- **Blocked requester does not block the other:** req0 is hazarded on r10 while req1 is independent → req1 is granted in that cycle and `stall_count` is unchanged.
- **Reset mid-stream:** assert `rst_n` low while both are valid → outputs return to bubble and tags clear. After release, req0 is granted first.
